// File: rtl/ps2_rx_deframer.sv
// ps2_rx_deframer: turns the raw PS/2 keyboard lines into scan-code bytes.
// The raw lines are synchronised, and ps2_clk passes through a majority-free
// run-length glitch filter. A frame FSM then samples ps2_data on each filtered
// falling edge.
// A good frame gives a one-cycle valid strobe with the byte on data. A bad frame
// gives a one-cycle error strobe and leaves data unchanged.
// Optional build macro PS2_RX_TIMEOUT_EN: aborts a stalled frame after
// TIMEOUT_CYCLES clk cycles without a falling edge.
module ps2_rx_deframer #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Frame is consistent when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic                  ps2_clk_meta_r, ps2_clk_sync_r;
    logic                  ps2_data_meta_r, ps2_data_sync_r;
    logic [FILTER_LEN-1:0] filt_hist_r;
    logic                  filt_clk_r, filt_clk_prev_r;
    logic                  fe_s, timeout_s;

    logic [1:0] state_r, state_nxt_s;
    logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0] shift_r, shift_nxt_s;
    logic       parity_r, parity_nxt_s;
    logic [7:0] data_r, data_nxt_s;
    logic       valid_r, valid_nxt_s;
    logic       error_r, error_nxt_s;
    logic       busy_r;

    // Two-flop synchronisers for both asynchronous PS/2 lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_meta_r  <= 1'b1;
            ps2_clk_sync_r  <= 1'b1;
            ps2_data_meta_r <= 1'b1;
            ps2_data_sync_r <= 1'b1;
        end else begin
            ps2_clk_meta_r  <= ps2_clk;
            ps2_clk_sync_r  <= ps2_clk_meta_r;
            ps2_data_meta_r <= ps2_data;
            ps2_data_sync_r <= ps2_data_meta_r;
        end
    end

    // Glitch filter: level changes only after FILTER_LEN identical samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_hist_r     <= {FILTER_LEN{1'b1}};
            filt_clk_r      <= 1'b1;
            filt_clk_prev_r <= 1'b1;
        end else begin
            filt_hist_r     <= {filt_hist_r[FILTER_LEN-2:0], ps2_clk_sync_r};
            filt_clk_prev_r <= filt_clk_r;
            if (&filt_hist_r) begin
                filt_clk_r <= 1'b1;
            end else if (~|filt_hist_r) begin
                filt_clk_r <= 1'b0;
            end else begin
                filt_clk_r <= filt_clk_r;
            end
        end
    end

    assign fe_s = filt_clk_prev_r & ~filt_clk_r;

`ifdef PS2_RX_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_r;

    assign timeout_s = (state_r != ST_IDLE) && !fe_s && (to_cnt_r >= TO_LAST);

    // Inter-edge watchdog: cleared by edges and in IDLE, saturates at all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r <= 16'd0;
        end else if (fe_s || timeout_s || (state_r == ST_IDLE)) begin
            to_cnt_r <= 16'd0;
        end else if (to_cnt_r != 16'hFFFF) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Frame FSM next-state: advances on filtered falling edges or on a timeout abort.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        parity_nxt_s  = parity_r;
        data_nxt_s    = data_r;
        valid_nxt_s   = 1'b0;
        error_nxt_s   = 1'b0;
        if (fe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (ps2_data_sync_r == 1'b0) begin
                        state_nxt_s   = ST_DATA;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        error_nxt_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_nxt_s[bit_cnt_r] = ps2_data_sync_r;
                    bit_cnt_nxt_s          = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    parity_nxt_s = ps2_data_sync_r;
                    state_nxt_s  = ST_STOP;
                end
                ST_STOP: begin
                    if (odd_parity_ok(shift_r, parity_r) && ps2_data_sync_r) begin
                        data_nxt_s  = shift_r;
                        valid_nxt_s = 1'b1;
                    end else begin
                        error_nxt_s = 1'b1;
                    end
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    bit_cnt_nxt_s = 3'd0;
                end
            endcase
        end else if (timeout_s) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 3'd0;
            error_nxt_s   = 1'b1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame FSM registers and registered output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            parity_r  <= parity_nxt_s;
            data_r    <= data_nxt_s;
            valid_r   <= valid_nxt_s;
            error_r   <= error_nxt_s;
            // Stays high one extra cycle so it covers the strobe cycle after the stop bit.
            busy_r    <= (state_nxt_s != ST_IDLE) || (state_r != ST_IDLE);
        end
    end

    assign data  = data_r;
    assign valid = valid_r;
    assign error = error_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_ps2_rx_deframer.sv
// Self-checking bench for ps2_rx_deframer: a directed frame table, hand-written
// corner sequences (stray start bit, reset mid-frame, stalled frame), and
// randomised frames checked against a frame-level reference model.
module tb_ps2_rx_deframer;

    localparam int HALF   = 16;
    localparam int FL     = 8;
    localparam int TO     = 1000;
    localparam int LAT_LO = 10;
    localparam int LAT_HI = 14;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       valid;
    logic       error;
    logic       busy;

    ps2_rx_deframer #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data), .valid(valid), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_valid;
        logic [7:0] d;
        int         t;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        bit         par;
        bit         stopv;
        bit         glitch;
        bit         drain;
        bit         exp_valid;
        logic [7:0] exp_data;
    } tv_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] last_good = 8'h00;
    int         last_fall = 0;
    logic [7:0] prev_data = 8'h00;
    bit         prev_rst = 1'b1;

    // Strobe monitor: logs every strobe and checks the strobe/data invariants.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid || error) begin
                obs_q.push_back('{valid, data, cyc});
                n_vec++;
                if (valid && error) begin
                    n_bad++;
                    $display("FAIL strobe_excl: got valid=1 error=1, want at most one high");
                end
            end
            if (!prev_rst && (data != prev_data)) begin
                n_vec++;
                if (!valid) begin
                    n_bad++;
                    $display("FAIL data_hold: data %h -> %h without valid, want change only with valid", prev_data, data);
                end
            end
        end
        prev_rst  = reset;
        prev_data = data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Device-side bit: data changes while the clock is high, then one low phase.
    task automatic send_bit(input bit b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            tick(4);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(HALF - 7);
        end else begin
            tick(HALF);
        end
        ps2_clk   = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stopv, input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(par, glitch);
        send_bit(stopv, glitch);
    endtask

    // Reference model: a frame is good when data+parity hold an odd count of ones and stop is 1.
    task automatic model_frame(input logic [7:0] d, input bit par, input bit stopv);
        if (((($countones(d) + int'(par)) % 2) == 1) && stopv) begin
            last_good = d;
            exp_q.push_back('{1'b1, d, last_fall});
        end else begin
            exp_q.push_back('{1'b0, last_good, last_fall});
        end
    endtask

    task automatic drain_and_check(input string tag);
        ev_t e;
        ev_t o;
        int  lat;
        tick(30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s_missing: got no strobe, want valid=%0b data=%h", tag, e.is_valid, e.d);
            end else begin
                o   = obs_q.pop_front();
                lat = o.t - e.t;
                if (o.is_valid !== e.is_valid || o.d !== e.d || lat < LAT_LO || lat > LAT_HI) begin
                    n_bad++;
                    $display("FAIL %s: got valid=%0b data=%h lat=%0d, want valid=%0b data=%h lat=%0d..%0d",
                             tag, o.is_valid, o.d, lat, e.is_valid, e.d, LAT_LO, LAT_HI);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s_extra: got valid=%0b data=%h, want no strobe", tag, o.is_valid, o.d);
        end
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    tv_t tbl [9];

    initial begin
        ev_t o;
        int  lat;
        bit  par;

        tbl = '{
            '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1C},
            '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1C},
            '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hF0},
            '{8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0},
            '{8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h29},
            '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A},
            '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hE0},
            '{8'h75, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h75},
            '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hF0}
        };

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(5);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(20);

        // Directed table; drain=0 rows run back-to-back into the next frame.
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].d, tbl[i].par, tbl[i].stopv, tbl[i].glitch);
            exp_q.push_back('{tbl[i].exp_valid, tbl[i].exp_data, last_fall});
            if (tbl[i].exp_valid) last_good = tbl[i].exp_data;
            if (tbl[i].drain) drain_and_check($sformatf("tbl%0d", i));
        end

        // Lone falling edge with data high while idle: treated as a bad start bit.
        send_bit(1'b1, 1'b0);
        exp_q.push_back('{1'b0, last_good, last_fall});
        drain_and_check("stray_start");

        // Reset after the 4th data bit: frame dropped, outputs back to reset values.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        last_good = 8'h00;
        tick(10);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        model_frame(8'h12, 1'b1, 1'b1);
        drain_and_check("after_reset");

        // Randomised frames with occasional parity/stop faults and random gaps.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            bit         sv;
            d   = 8'($urandom);
            par = ~(^d) ^ ($urandom_range(0, 7) == 0);
            sv  = ($urandom_range(0, 7) != 0);
            send_frame(d, par, sv, 1'b0);
            model_frame(d, par, sv);
            if ($urandom_range(0, 1) == 1) drain_and_check($sformatf("rnd%0d", i));
        end
        drain_and_check("rnd_end");

        // Stalled frame: clock stops after 5 data bits.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
`ifdef PS2_RX_TIMEOUT_EN
        tick(TO + 100);
        check("to_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) begin
            o   = obs_q.pop_front();
            lat = o.t - last_fall;
            n_vec++;
            if (o.is_valid || o.d !== last_good || lat < TO + 5 || lat > TO + 20) begin
                n_bad++;
                $display("FAIL timeout_err: got valid=%0b data=%h lat=%0d, want error data=%h lat=%0d..%0d",
                         o.is_valid, o.d, lat, last_good, TO + 5, TO + 20);
            end
        end
        obs_q.delete();
        check("to_busy", 32'(busy), 32'd0);
`else
        tick(TO + 500);
        check("noto_strobes", 32'(obs_q.size()), 32'd0);
        check("noto_busy", 32'(busy), 32'd1);
        obs_q.delete();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        last_good = 8'h00;
        tick(10);
`endif
        send_frame(8'h76, 1'b0, 1'b1, 1'b0);
        model_frame(8'h76, 1'b0, 1'b1);
        drain_and_check("after_stall");
        check("final_data", 32'(data), 32'h76);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
